pipe_addsub: RTL

Parametrised, pipelined adder/subtractor for the RV32I datapath. It is the successor to the single-cycle 32-bit ripple-carry adder. The carry chain is split into `STAGES` registered slices so the ALU add path can close timing at higher clock rates. It adds subtraction, carry-in, status flags (carry, overflow, zero, negative) and a valid/ready handshake with full backpressure. It sits between the ALU operand muxes and the writeback/branch-compare logic.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_slice.sv | 44 ++++
 rtl/pipe_addsub.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration-time helpers for the pipelined adder/subtractor.
package addsub_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } addsub_flags_t;

    localparam int ADDSUB_DEFAULT_WIDTH  = 32;
    localparam int ADDSUB_DEFAULT_STAGES = 4;

    // The carry chain is cut into equal slices, so WIDTH must divide evenly.
    function automatic bit addsub_params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Full-adder cell and the combinational SW-bit ripple slice built from it.
module addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_slice
    import addsub_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb,
    output logic          zero
);
    logic [SW:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        addsub_fa u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(carry[i]),
            .s (sum[i]),
            .co(carry[i+1])
        );
    end

    // cmsb is only meaningful for the top slice, where it feeds overflow detection.
    assign cout = carry[SW];
    assign cmsb = carry[SW-1];
    assign zero = (sum == '0);
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: STAGES registered ripple slices with operand skew,
// result deskew, running zero detect and a valid/ready handshake with full backpressure.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = ADDSUB_DEFAULT_WIDTH,
    parameter int STAGES = ADDSUB_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SW        = WIDTH / STAGES;
    localparam bit PARAMS_OK = addsub_params_ok(WIDTH, STAGES);

    if (!PARAMS_OK) begin : g_param_check
        $error("pipe_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    logic             adv;
    logic [WIDTH-1:0] op_a    [STAGES];
    logic [WIDTH-1:0] op_b    [STAGES];
    logic [WIDTH-1:0] sum_c   [STAGES];
    logic             carry_c [STAGES];
    logic             zero_c  [STAGES];
    logic             vld_c   [STAGES];
    logic             ovf_d;
    logic             ovf_q;
    addsub_flags_t    flags;

    // The whole pipe moves as one: a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    assign op_a[0] = a;
    assign op_b[0] = b ^ {WIDTH{sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             prev_vld;
        logic             prev_zero;
        logic [WIDTH-1:0] prev_sum;
        logic             slice_cin;
        logic [SW-1:0]    s_sum;
        logic             s_cout;
        logic             s_cmsb;
        logic             s_zero;
        logic             vld_d;
        logic             vld_q;
        logic             carry_d;
        logic             carry_q;
        logic             zero_d;
        logic             zero_q;
        logic [WIDTH-1:0] sum_d;
        logic [WIDTH-1:0] sum_q;

        if (k == 0) begin : g_head
            assign prev_vld  = in_valid;
            assign prev_zero = 1'b1;
            assign prev_sum  = '0;
            assign slice_cin = sub | cin;
        end else begin : g_body
            assign prev_vld  = vld_c[k-1];
            assign prev_zero = zero_c[k-1];
            assign prev_sum  = sum_c[k-1];
            assign slice_cin = carry_c[k-1];
        end

        addsub_slice #(.SW(SW)) u_slice (
            .a   (op_a[k][k*SW +: SW]),
            .b   (op_b[k][k*SW +: SW]),
            .cin (slice_cin),
            .sum (s_sum),
            .cout(s_cout),
            .cmsb(s_cmsb),
            .zero(s_zero)
        );

        // Lower slices ride along in sum_d so all slices leave the pipe together.
        always_comb begin
            vld_d   = vld_q;
            sum_d   = sum_q;
            carry_d = carry_q;
            zero_d  = zero_q;
            if (adv) begin
                vld_d               = prev_vld;
                sum_d               = prev_sum;
                sum_d[k*SW +: SW]   = s_sum;
                carry_d             = s_cout;
                zero_d              = prev_zero & s_zero;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q   <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                zero_q  <= 1'b0;
            end else begin
                vld_q   <= vld_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end

        assign vld_c[k]   = vld_q;
        assign sum_c[k]   = sum_q;
        assign carry_c[k] = carry_q;
        assign zero_c[k]  = zero_q;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (adv) begin
                    a_d = op_a[k];
                    b_d = op_b[k];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign op_a[k+1] = a_q;
            assign op_b[k+1] = b_q;
        end else begin : g_tail
            always_comb begin
                ovf_d = ovf_q;
                if (adv) begin
                    ovf_d = s_cmsb ^ s_cout;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign flags.cout = carry_c[STAGES-1];
    assign flags.ovf  = ovf_q;
    assign flags.zero = zero_c[STAGES-1];
    assign flags.neg  = sum_c[STAGES-1][WIDTH-1];

    assign out_valid = vld_c[STAGES-1];
    assign sum       = sum_c[STAGES-1];
    assign cout      = flags.cout;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;
    assign neg       = flags.neg;
endmodule
